fetch_addr_sequencer: RTL and testbench

- Raster-scan controller that drives the fetch-stage address register of the 2-stage sharpening pipeline.
- It generates the nine 3x3 window read addresses in the zero-padded 802x602 source image. It also generates the matching output-pixel address in the 800x600 result image.
- Each window step is advanced only when the downstream stage accepts it (valid/ready).
- Frame start, abort and completion are signalled to the top-level control.

---
 rtl/fetch_addr_sequencer_pkg.sv | 47 ++++
 rtl/fetch_addr_sequencer_window_addr_gen.sv | 17 +
 rtl/fetch_addr_sequencer.sv | 161 ++++++++++++++++
 tb/tb_fetch_addr_sequencer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_addr_sequencer_pkg.sv
// Shared constants, types and helpers for the fetch-stage address sequencer.
// Geometry defaults describe an 800x600 output read from a zero-padded 802x602 source.
package fetch_addr_sequencer_pkg;

    localparam int unsigned IMG_W = 800;
    localparam int unsigned IMG_H = 600;
    localparam int unsigned PAD_W = IMG_W + 2;
    localparam int unsigned AW    = 19;
    localparam int unsigned CW    = 10;
    localparam int unsigned NWIN  = 9;

    typedef logic [AW-1:0]  addr_t;
    typedef logic [CW-1:0]  cnt_t;
    typedef addr_t [NWIN-1:0] win_t;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StRun   = 2'd1,
        StFlush = 2'd2
    } state_e;

    // Offset of tap k (row-major, top-left first) from the window base.
    function automatic addr_t win_off(input int unsigned k, input int unsigned pad_w);
        return addr_t'((k / 3) * pad_w + (k % 3));
    endfunction

    function automatic win_t reset_win(input int unsigned pad_w);
        win_t w;
        for (int unsigned k = 0; k < NWIN; k++) begin
            w[k] = win_off(k, pad_w);
        end
        return w;
    endfunction

    localparam addr_t OFF0 = win_off(0, PAD_W);
    localparam addr_t OFF1 = win_off(1, PAD_W);
    localparam addr_t OFF2 = win_off(2, PAD_W);
    localparam addr_t OFF3 = win_off(3, PAD_W);
    localparam addr_t OFF4 = win_off(4, PAD_W);
    localparam addr_t OFF5 = win_off(5, PAD_W);
    localparam addr_t OFF6 = win_off(6, PAD_W);
    localparam addr_t OFF7 = win_off(7, PAD_W);
    localparam addr_t OFF8 = win_off(8, PAD_W);

    localparam win_t RST_WIN = reset_win(PAD_W);

endpackage

// File: rtl/fetch_addr_sequencer_window_addr_gen.sv
// Combinational 3x3 window address generator: base plus the nine fixed tap offsets.
// The parent registers the result.
module fetch_addr_sequencer_window_addr_gen
    import fetch_addr_sequencer_pkg::*;
#(
    parameter int unsigned PadW = PAD_W
) (
    input  addr_t base_i,
    output win_t  win_o
);

    for (genvar k = 0; k < NWIN; k++) begin : g_tap
        localparam addr_t Off = win_off(k, PadW);
        assign win_o[k] = base_i + Off;
    end

endmodule

// File: rtl/fetch_addr_sequencer.sv
// Raster-scan fetch address sequencer: walks a 3x3 window over the padded source image
// one valid/ready handshake at a time and reports frame start, abort and completion.
module fetch_addr_sequencer
    import fetch_addr_sequencer_pkg::*;
#(
    parameter int unsigned ImgW = IMG_W,
    parameter int unsigned ImgH = IMG_H,
    parameter int unsigned PadW = ImgW + 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          abort,
    input  logic          ready,
    output logic          valid,
    output logic [AW-1:0] a0,
    output logic [AW-1:0] a1,
    output logic [AW-1:0] a2,
    output logic [AW-1:0] a3,
    output logic [AW-1:0] a4,
    output logic [AW-1:0] a5,
    output logic [AW-1:0] a6,
    output logic [AW-1:0] a7,
    output logic [AW-1:0] a8,
    output logic [AW-1:0] oaddr,
    output logic          last,
    output logic          busy,
    output logic          done
);

    localparam cnt_t  ColMax   = cnt_t'(ImgW - 1);
    localparam cnt_t  RowMax   = cnt_t'(ImgH - 1);
    // Stepping off the end of a row also skips the right and left pad columns.
    localparam addr_t WrapStep = addr_t'(PadW - ImgW + 1);
    localparam win_t  RstWin   = reset_win(PadW);

    state_e state_q, state_d;
    cnt_t   row_q, row_d;
    cnt_t   col_q, col_d;
    addr_t  base_q, base_d;
    addr_t  oaddr_q, oaddr_d;
    win_t   win_q, win_d;
    logic   last_q, last_d;
    logic   valid_q, valid_d;
    logic   busy_q, busy_d;
    logic   done_q, done_d;
    logic   accept;

    fetch_addr_sequencer_window_addr_gen #(
        .PadW(PadW)
    ) u_window_addr_gen (
        .base_i(base_d),
        .win_o (win_d)
    );

    assign accept = valid_q && ready;

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        base_d  = base_q;
        oaddr_d = oaddr_q;
        last_d  = last_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    state_d = StRun;
                    row_d   = '0;
                    col_d   = '0;
                    base_d  = '0;
                    oaddr_d = '0;
                    last_d  = (RowMax == '0) && (ColMax == '0);
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                end else if (accept) begin
                    if (last_q) begin
                        // Final window taken: hold its addresses, pulse done next cycle.
                        state_d = StFlush;
                        valid_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (col_q == ColMax) begin
                            col_d  = '0;
                            row_d  = row_q + 1'b1;
                            base_d = base_q + WrapStep;
                        end else begin
                            col_d  = col_q + 1'b1;
                            base_d = base_q + 1'b1;
                        end
                        oaddr_d = oaddr_q + 1'b1;
                        last_d  = (row_d == RowMax) && (col_d == ColMax);
                    end
                end
            end
            StFlush: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = StIdle;
                valid_d = 1'b0;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            row_q   <= '0;
            col_q   <= '0;
            base_q  <= '0;
            oaddr_q <= '0;
            win_q   <= RstWin;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            base_q  <= base_d;
            oaddr_q <= oaddr_d;
            win_q   <= win_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign valid = valid_q;
    assign busy  = busy_q;
    assign done  = done_q;
    assign last  = last_q;
    assign oaddr = oaddr_q;
    assign a0    = win_q[0];
    assign a1    = win_q[1];
    assign a2    = win_q[2];
    assign a3    = win_q[3];
    assign a4    = win_q[4];
    assign a5    = win_q[5];
    assign a6    = win_q[6];
    assign a7    = win_q[7];
    assign a8    = win_q[8];

endmodule

// File: tb/tb_fetch_addr_sequencer.sv
// Bench for fetch_addr_sequencer: a full-size instance for row wrap, abort and reset,
// plus a 7x5 instance so whole frames (last/done) fit in a short run.
module tb_fetch_addr_sequencer;

    localparam int SW = 7;
    localparam int SH = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_s [2];
    logic              start_s [2];
    logic              abort_s [2];
    logic              ready_s [2];
    logic              valid_s [2];
    logic              last_s  [2];
    logic              busy_s  [2];
    logic              done_s  [2];
    logic [18:0]       oaddr_s [2];
    logic [8:0][18:0]  a_s     [2];

    int n_total = 0;
    int n_bad   = 0;

    fetch_addr_sequencer u_big (
        .clk(clk), .reset(reset_s[0]), .start(start_s[0]), .abort(abort_s[0]),
        .ready(ready_s[0]), .valid(valid_s[0]),
        .a0(a_s[0][0]), .a1(a_s[0][1]), .a2(a_s[0][2]), .a3(a_s[0][3]), .a4(a_s[0][4]),
        .a5(a_s[0][5]), .a6(a_s[0][6]), .a7(a_s[0][7]), .a8(a_s[0][8]),
        .oaddr(oaddr_s[0]), .last(last_s[0]), .busy(busy_s[0]), .done(done_s[0])
    );

    fetch_addr_sequencer #(
        .ImgW(SW),
        .ImgH(SH)
    ) u_sml (
        .clk(clk), .reset(reset_s[1]), .start(start_s[1]), .abort(abort_s[1]),
        .ready(ready_s[1]), .valid(valid_s[1]),
        .a0(a_s[1][0]), .a1(a_s[1][1]), .a2(a_s[1][2]), .a3(a_s[1][3]), .a4(a_s[1][4]),
        .a5(a_s[1][5]), .a6(a_s[1][6]), .a7(a_s[1][7]), .a8(a_s[1][8]),
        .oaddr(oaddr_s[1]), .last(last_s[1]), .busy(busy_s[1]), .done(done_s[1])
    );

    function automatic int wid(input int d);
        return (d == 0) ? 800 : SW;
    endfunction

    function automatic int hgt(input int d);
        return (d == 0) ? 600 : SH;
    endfunction

    // Tap k of the n-th window of a frame, from raster position in the padded image.
    function automatic longint exp_addr(input int d, input int n, input int k);
        int w  = wid(d);
        int pw = w + 2;
        int r  = n / w;
        int c  = n % w;
        return longint'((r + k / 3) * pw + c + k % 3);
    endfunction

    task automatic check_eq(input string tag, input longint got, input longint exp);
        n_total++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_win(input int d, input int n);
        check_eq("valid", longint'(valid_s[d]), 1);
        check_eq("busy", longint'(busy_s[d]), 1);
        check_eq("done_run", longint'(done_s[d]), 0);
        check_eq("oaddr", longint'(oaddr_s[d]), longint'(n));
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("a%0d@%0d", k, n), longint'(a_s[d][k]), exp_addr(d, n, k));
        end
        check_eq("last", longint'(last_s[d]), longint'(n == wid(d) * hgt(d) - 1));
    endtask

    task automatic check_reset(input int d, input string tag);
        check_eq({tag, "_valid"}, longint'(valid_s[d]), 0);
        check_eq({tag, "_busy"}, longint'(busy_s[d]), 0);
        check_eq({tag, "_done"}, longint'(done_s[d]), 0);
        check_eq({tag, "_last"}, longint'(last_s[d]), 0);
        check_eq({tag, "_oaddr"}, longint'(oaddr_s[d]), 0);
        for (int k = 0; k < 9; k++) begin
            check_eq($sformatf("%s_a%0d", tag, k), longint'(a_s[d][k]), exp_addr(d, 0, k));
        end
    endtask

    // Accept `count` windows starting at index n0 under random backpressure,
    // optionally poking start while busy; outputs must track the model every cycle.
    task automatic stream(input int d, input int n0, input int count, input int pct,
                          input bit poke_start);
        int n      = n0;
        int budget = count * 20 + 50;
        while (n < n0 + count && budget > 0) begin
            ready_s[d] = ($urandom_range(99) < pct);
            start_s[d] = poke_start && ($urandom_range(3) == 0);
            check_win(d, n);
            tick();
            if (ready_s[d]) n++;
            budget--;
        end
        ready_s[d] = 1'b0;
        start_s[d] = 1'b0;
        check_eq("stream_count", longint'(n - n0), longint'(count));
    endtask

    initial begin
        for (int d = 0; d < 2; d++) begin
            reset_s[d] = 1'b0;
            start_s[d] = 1'b0;
            abort_s[d] = 1'b0;
            ready_s[d] = 1'b0;
        end
        repeat (3) tick();
        check_reset(0, "rst_big");
        check_reset(1, "rst_sml");
        check_eq("rst_a3", longint'(a_s[0][3]), 802);
        check_eq("rst_a8", longint'(a_s[0][8]), 1606);
        reset_s[0] = 1'b1;
        reset_s[1] = 1'b1;
        tick();
        check_eq("idle_valid", longint'(valid_s[0]), 0);

        // Full-size frame: first row at full rate, then row wrap.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        stream(0, 0, 800, 100, 1'b0);
        check_eq("wrap_a0", longint'(a_s[0][0]), 802);
        check_eq("wrap_a4", longint'(a_s[0][4]), 1605);
        check_eq("wrap_oaddr", longint'(oaddr_s[0]), 800);

        // Backpressure with stray starts, then abort mid-row at oaddr 1234.
        stream(0, 800, 434, 60, 1'b1);
        abort_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        tick();
        abort_s[0] = 1'b0;
        ready_s[0] = 1'b0;
        check_eq("abort_valid", longint'(valid_s[0]), 0);
        check_eq("abort_busy", longint'(busy_s[0]), 0);
        check_eq("abort_oaddr", longint'(oaddr_s[0]), 1234);
        check_eq("abort_a0", longint'(a_s[0][0]), exp_addr(0, 1234, 0));
        repeat (3) begin
            check_eq("abort_done", longint'(done_s[0]), 0);
            tick();
        end

        // Start and abort together while idle: abort wins.
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        check_eq("sa_valid", longint'(valid_s[0]), 0);
        check_eq("sa_busy", longint'(busy_s[0]), 0);

        // Restart from zero, run to oaddr 5000, then reset with start and abort held.
        start_s[0] = 1'b1;
        tick();
        start_s[0] = 1'b0;
        stream(0, 0, 5000, 50, 1'b1);
        reset_s[0] = 1'b0;
        start_s[0] = 1'b1;
        abort_s[0] = 1'b1;
        ready_s[0] = 1'b1;
        tick();
        check_reset(0, "midrst");
        reset_s[0] = 1'b1;
        tick();
        check_eq("post_rst_valid", longint'(valid_s[0]), 0);
        check_eq("post_rst_busy", longint'(busy_s[0]), 0);
        start_s[0] = 1'b0;
        abort_s[0] = 1'b0;
        ready_s[0] = 1'b0;

        // Small image: whole frames, flush/done timing and start overlapping done.
        for (int f = 0; f < 3; f++) begin
            start_s[1] = 1'b1;
            tick();
            start_s[1] = 1'b0;
            stream(1, 0, SW * SH, 30 + f * 30, 1'b1);
            check_eq("flush_valid", longint'(valid_s[1]), 0);
            check_eq("flush_done", longint'(done_s[1]), 1);
            check_eq("flush_busy", longint'(busy_s[1]), 1);
            check_eq("flush_oaddr", longint'(oaddr_s[1]), longint'(SW * SH - 1));
            check_eq("flush_a8", longint'(a_s[1][8]), exp_addr(1, SW * SH - 1, 8));
            start_s[1] = 1'b1;
            tick();
            start_s[1] = 1'b0;
            check_eq("end_done", longint'(done_s[1]), 0);
            check_eq("end_busy", longint'(busy_s[1]), 0);
            check_eq("end_valid", longint'(valid_s[1]), 0);
            check_eq("end_a0", longint'(a_s[1][0]), exp_addr(1, SW * SH - 1, 0));
            tick();
            check_eq("noqueue_valid", longint'(valid_s[1]), 0);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
